sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port SRAM among NumPorts requesters.
// Define SRAM_ARB_LOCK_EN to add per-port lock_i and an UNLOCKED/LOCKED grant lock.
module sram_port_arbiter #(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 4,
    parameter int DataWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           req_valid_i,
    output logic [NumPorts-1:0]           req_ready_o,
    input  logic [NumPorts-1:0]           req_we_i,
    input  logic [NumPorts*AddrWidth-1:0] req_addr_i,
    input  logic [NumPorts*DataWidth-1:0] req_wdata_i,
    output logic [NumPorts-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    input  logic [DataWidth-1:0]          sram_rdata_i
`ifdef SRAM_ARB_LOCK_EN
    ,
    input  logic [NumPorts-1:0]           lock_i
`endif
);

    localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0]     r_rr_ptr;
    logic [NumPorts-1:0] r_rsp_valid;
    logic [NumPorts-1:0] w_elig;
    logic [PtrW-1:0]     w_gnt_idx;
    logic [PtrW-1:0]     w_next_ptr;
    logic                w_found;
    logic                w_hs;

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;
    state_t          r_state;
    logic [PtrW-1:0] r_lock_port;

    always_comb begin
        w_elig = req_valid_i;
        if (r_state == ST_LOCKED)
            w_elig = req_valid_i & (NumPorts'(1) << r_lock_port);
    end
`else
    always_comb w_elig = req_valid_i;
`endif

    // Scan from rr_ptr upward, wrapping; first eligible port wins.
    always_comb begin
        int v_idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        v_idx     = 0;
        for (int i = 0; i < NumPorts; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NumPorts)
                v_idx = v_idx - NumPorts;
            if (!w_found && w_elig[v_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = PtrW'(v_idx);
            end
        end
    end

    assign w_hs        = w_found & ~rst_i;
    assign w_next_ptr  = (w_gnt_idx == PtrW'(NumPorts - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign req_ready_o = w_hs ? (NumPorts'(1) << w_gnt_idx) : '0;

    assign sram_req_o   = w_hs;
    assign sram_we_o    = w_hs & req_we_i[w_gnt_idx];
    assign sram_addr_o  = req_addr_i[w_gnt_idx*AddrWidth +: AddrWidth];
    assign sram_wdata_o = req_wdata_i[w_gnt_idx*DataWidth +: DataWidth];

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = (|r_rsp_valid) ? sram_rdata_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_hs && !req_we_i[w_gnt_idx])
                r_rsp_valid[w_gnt_idx] <= 1'b1;
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_state     <= ST_UNLOCKED;
            r_lock_port <= '0;
        end else begin
            unique case (r_state)
                ST_UNLOCKED: begin
                    if (w_hs) begin
                        r_rr_ptr <= w_next_ptr;
                        if (lock_i[w_gnt_idx]) begin
                            r_state     <= ST_LOCKED;
                            r_lock_port <= w_gnt_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Pointer is frozen while locked; release resumes after the owner.
                    if (w_hs && !lock_i[w_gnt_idx]) begin
                        r_state  <= ST_UNLOCKED;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_UNLOCKED;
            endcase
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rr_ptr <= '0;
        else if (w_hs)
            r_rr_ptr <= w_next_ptr;
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural 16x32 SRAM.
// Lock scenario is compiled in when SRAM_ARB_LOCK_EN is defined.
module tb_sram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid, ready, we, rsp_valid;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [31:0]  rdata;
    logic         sram_req, sram_we;
    logic [3:0]   sram_addr;
    logic [31:0]  sram_wdata, sram_rdata;
`ifdef SRAM_ARB_LOCK_EN
    logic [3:0]   lock;
`endif
    logic [31:0]  mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NumPorts(4), .AddrWidth(4), .DataWidth(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_we_i     (we),
        .req_addr_i   (addr),
        .req_wdata_i  (wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
`ifdef SRAM_ARB_LOCK_EN
        ,
        .lock_i       (lock)
`endif
    );

    // SRAM model: word i resets to 0x1000+i, reads return one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
            sram_rdata <= '0;
        end else if (sram_req) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 4'hF;
        we = 4'h0;
        addr = 16'h3210;
        wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
        lock = 4'h0;
`endif
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 0000", ready);
        end
        n_cmp++;
        if (sram_req !== 1'b0 || sram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_sram got req=%b we=%b want 0 0", sram_req, sram_we);
        end
        n_cmp++;
        if (rsp_valid !== 4'h0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rsp got %b/%h want 0000/0", rsp_valid, rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 4'h0;
    endtask

    task automatic test_rr_order();
        logic [1:0] exp [5];
        logic [3:0] exp_rsp;
        exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        valid = 4'hF;
        we = 4'h0;
        addr = 16'h3210;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ready !== (4'(1) << exp[k]) || sram_req !== 1'b1 ||
                sram_addr !== {2'b00, exp[k]}) begin
                n_bad++;
                $display("FAIL rr_grant%0d got rdy=%b addr=%0d want port %0d",
                         k, ready, sram_addr, exp[k]);
            end
            exp_rsp = (k > 0) ? (4'(1) << exp[k-1]) : 4'h0;
            n_cmp++;
            if (rsp_valid !== exp_rsp ||
                (k > 0 && rdata !== 32'h1000 + 32'(exp[k-1]))) begin
                n_bad++;
                $display("FAIL rr_rsp%0d got %b/%h want %b", k, rsp_valid, rdata, exp_rsp);
            end
            step();
        end
        valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rdata !== 32'h1000) begin
            n_bad++;
            $display("FAIL rr_last_rsp got %b/%h want 0001/00001000", rsp_valid, rdata);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL rr_rsp_single got %b want 0000", rsp_valid);
        end
        step();
    endtask

    task automatic test_write_read();
        valid = 4'b0100;
        we = 4'b0100;
        addr = 16'h0500;
        wdata = {32'h0, 32'hDEADBEEF, 64'h0};
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0100 || sram_we !== 1'b1 || sram_addr !== 4'd5 ||
            sram_wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_issue got rdy=%b we=%b a=%0d d=%h want 0100 1 5 deadbeef",
                     ready, sram_we, sram_addr, sram_wdata);
        end
        step();
        valid = 4'b0001;
        we = 4'b0000;
        addr = 16'h0005;
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0001 || sram_we !== 1'b0 || rsp_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL rd_issue got rdy=%b we=%b rsp=%b want 0001 0 0000",
                     ready, sram_we, rsp_valid);
        end
        step();
        valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL raw_rdata got %b/%h want 0001/deadbeef", rsp_valid, rdata);
        end
        step();
    endtask

    task automatic test_idle();
        valid = 4'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ready !== 4'h0 || sram_req !== 1'b0 || sram_we !== 1'b0) begin
                n_bad++;
                $display("FAIL idle%0d got rdy=%b req=%b we=%b want 0", k, ready, sram_req, sram_we);
            end
            step();
        end
        // Pointer must still be 1: with ports 0 and 2 valid, port 2 wins.
        valid = 4'b0101;
        addr = 16'h0000;
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL idle_ptr_hold got %b want 0100", ready);
        end
        step();
        valid = 4'h0;
        step();
    endtask

    task automatic test_wrap();
        valid = 4'b0011;
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_first got %b want 0001", ready);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_second got %b want 0010", ready);
        end
        step();
        valid = 4'h0;
        step();
    endtask

`ifdef SRAM_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] v_seq [6];
        logic [3:0] l_seq [6];
        logic [3:0] r_seq [6];
        v_seq = '{4'b0010, 4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1101};
        l_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        r_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
        we = 4'h0;
        for (int k = 0; k < 6; k++) begin
            valid = v_seq[k];
            lock = l_seq[k];
            @(negedge clk);
            n_cmp++;
            if (ready !== r_seq[k]) begin
                n_bad++;
                $display("FAIL lock_step%0d got %b want %b", k, ready, r_seq[k]);
            end
            step();
        end
        valid = 4'h0;
        lock = 4'h0;
        step();
    endtask
`endif

    task automatic test_reset_mid_read();
        valid = 4'b1000;
        we = 4'h0;
        addr = 16'h7000;
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL rstmid_grant got %b want 1000", ready);
        end
        step();
        rst = 1'b1;
        valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'h0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rstmid_suppress got %b/%h want 0000/0", rsp_valid, rdata);
        end
        step();
        rst = 1'b0;
        valid = 4'hF;
        addr = 16'h3210;
        @(negedge clk);
        n_cmp++;
        if (ready !== 4'b0001 || rsp_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL rstmid_after got rdy=%b rsp=%b want 0001 0000", ready, rsp_valid);
        end
        step();
        valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rdata !== 32'h1000) begin
            n_bad++;
            $display("FAIL rstmid_rsp got %b/%h want 0001/00001000", rsp_valid, rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_write_read();
        test_idle();
        test_wrap();
`ifdef SRAM_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
